instr_fetch_issue: RTL and testbench

Program sequencer for the 16-bit stack-machine core. Fetches instructions from a synchronous program memory, resolves control-flow groups (push_pc = call, pop_pc = return/halt) locally with a return-address stack, and issues all other instructions to the stack execute unit over a valid/ready handshake. It is the producer side of the instruction interface the execute unit consumes.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/ret_addr_stack.sv | 44 ++++
 rtl/instr_fetch_issue.sv | 142 ++++++++++++++
 tb/tb_instr_fetch_issue.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared encodings and state type for the instruction fetch/issue sequencer.
package fetch_pkg;
    localparam logic [2:0] GRP_PUSH_PC = 3'b110;
    localparam logic [2:0] GRP_POP_PC  = 3'b111;
    localparam logic [2:0] OP_HALT     = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_ISSUE,
        ST_HALT,
        ST_ERR
    } state_t;
endpackage

// File: rtl/ret_addr_stack.sv
// Return-address LIFO; slot 0 is unused so the occupancy count addresses the top entry directly.
module ret_addr_stack #(
    parameter int RAS_DEPTH = 8,
    parameter int PC_W      = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] din,
    output logic [PC_W-1:0] top,
    output logic            full,
    output logic            empty
);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [PC_W-1:0]  mem [0:RAS_DEPTH];
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] wr_idx;

    assign wr_idx = count + CNT_W'(1);
    assign full   = (count == CNT_W'(RAS_DEPTH));
    assign empty  = (count == '0);
    assign top    = mem[count];

    always_ff @(posedge clk) begin
        if (push && !full && !clr) begin
            mem[wr_idx] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (push && !full) begin
            count <= count + CNT_W'(1);
        end else if (pop && !empty) begin
            count <= count - CNT_W'(1);
        end
    end
endmodule

// File: rtl/instr_fetch_issue.sv
// Program sequencer: fetches, resolves call/return/halt locally, issues the rest downstream.
//
// state     | meaning
// ST_IDLE   | waiting for start after reset
// ST_FETCH  | imem read in flight for pc
// ST_DECODE | instruction word available, resolve control flow
// ST_ISSUE  | holding instruction for execute unit handshake
// ST_HALT   | halt executed, wait for start
// ST_ERR    | return-stack overflow/underflow, wait for start
module instr_fetch_issue
    import fetch_pkg::*;
#(
    parameter int PC_W      = 10,
    parameter int RAS_DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            imem_en,
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_rdata,
    output logic            issue_valid,
    input  logic            issue_ready,
    output logic [15:0]     issue_instr,
    output logic [PC_W-1:0] issue_pc,
    output logic            halted,
    output logic            ras_err
);
    state_t          state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] call_tgt;
    logic [2:0]      grp;
    logic [2:0]      op;
    logic            is_call;
    logic            is_halt;
    logic            is_ret;
    logic            restart;
    logic            ras_push;
    logic            ras_pop;
    logic [PC_W-1:0] ras_top;
    logic            ras_full;
    logic            ras_empty;

    assign grp      = imem_rdata[15:13];
    assign op       = imem_rdata[12:10];
    assign call_tgt = imem_rdata[PC_W-1:0];
    assign pc_inc   = pc + PC_W'(1);
    assign is_call  = (grp == GRP_PUSH_PC);
    assign is_halt  = (grp == GRP_POP_PC) && (op == OP_HALT);
    assign is_ret   = (grp == GRP_POP_PC) && (op != OP_HALT);
    assign restart  = start && (state == ST_IDLE || state == ST_HALT || state == ST_ERR);
    assign ras_push = (state == ST_DECODE) && is_call && !ras_full;
    assign ras_pop  = (state == ST_DECODE) && is_ret && !ras_empty;

    ret_addr_stack #(
        .RAS_DEPTH (RAS_DEPTH),
        .PC_W      (PC_W)
    ) u_ras (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (restart),
        .push  (ras_push),
        .pop   (ras_pop),
        .din   (pc_inc),
        .top   (ras_top),
        .full  (ras_full),
        .empty (ras_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            pc          <= '0;
            imem_en     <= 1'b0;
            imem_addr   <= '0;
            issue_valid <= 1'b0;
            issue_instr <= '0;
            issue_pc    <= '0;
            halted      <= 1'b0;
            ras_err     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_HALT, ST_ERR: begin
                    if (start) begin
                        state     <= ST_FETCH;
                        pc        <= '0;
                        imem_en   <= 1'b1;
                        imem_addr <= '0;
                        halted    <= 1'b0;
                        ras_err   <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    imem_en <= 1'b0;
                    state   <= ST_DECODE;
                end
                ST_DECODE: begin
                    if (is_call) begin
                        if (ras_full) begin
                            ras_err <= 1'b1;
                            state   <= ST_ERR;
                        end else begin
                            pc        <= call_tgt;
                            imem_addr <= call_tgt;
                            imem_en   <= 1'b1;
                            state     <= ST_FETCH;
                        end
                    end else if (is_halt) begin
                        halted <= 1'b1;
                        state  <= ST_HALT;
                    end else if (is_ret) begin
                        if (ras_empty) begin
                            ras_err <= 1'b1;
                            state   <= ST_ERR;
                        end else begin
                            pc        <= ras_top;
                            imem_addr <= ras_top;
                            imem_en   <= 1'b1;
                            state     <= ST_FETCH;
                        end
                    end else begin
                        issue_valid <= 1'b1;
                        issue_instr <= imem_rdata;
                        issue_pc    <= pc;
                        state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (issue_ready) begin
                        issue_valid <= 1'b0;
                        pc          <= pc_inc;
                        imem_addr   <= pc_inc;
                        imem_en     <= 1'b1;
                        state       <= ST_FETCH;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_fetch_issue.sv
// Scoreboard bench for instr_fetch_issue: expected issues queued at setup, popped on handshake.
module tb_instr_fetch_issue;
    localparam int PC_W = 10;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            imem_en;
    logic [PC_W-1:0] imem_addr;
    logic [15:0]     imem_rdata = '0;
    logic            issue_valid;
    logic            issue_ready = 1'b0;
    logic [15:0]     issue_instr;
    logic [PC_W-1:0] issue_pc;
    logic            halted;
    logic            ras_err;

    logic [15:0] mem [0:1023];
    logic [25:0] exp_q [$];
    int          hs_cyc [$];
    int          hs_count = 0;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    instr_fetch_issue #(.PC_W(PC_W), .RAS_DEPTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .imem_en     (imem_en),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_instr (issue_instr),
        .issue_pc    (issue_pc),
        .halted      (halted),
        .ras_err     (ras_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (imem_en) imem_rdata <= mem[imem_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && issue_valid && issue_ready) begin
            logic [25:0] e;
            hs_count++;
            hs_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                check_eq("extra_issue", issue_pc, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check_eq("issue_instr", issue_instr, e[25:10]);
                check_eq("issue_pc", issue_pc, e[9:0]);
            end
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) mem[i] = 16'hFFFF;
    endtask

    task automatic pulse_start(output int s);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        s = cyc;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!(halted || ras_err) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("done_timeout", halted | ras_err, 1);
    endtask

    initial begin
        int s;
        int h0;
        int n;
        clear_mem();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_imem_en", imem_en, 0);
        check_eq("rst_valid", issue_valid, 0);
        check_eq("rst_addr", imem_addr, 0);
        check_eq("rst_halted", halted, 0);
        check_eq("rst_ras_err", ras_err, 0);

        // linear program
        mem[0] = 16'h0005; mem[1] = 16'h2401; mem[2] = 16'hFFFF;
        exp_q.push_back({16'h0005, 10'd0});
        exp_q.push_back({16'h2401, 10'd1});
        hs_cyc.delete();
        issue_ready = 1'b1;
        pulse_start(s);
        wait_done(40);
        repeat (4) @(posedge clk);
        #1;
        check_eq("lin_halted", halted, 1);
        check_eq("lin_err", ras_err, 0);
        check_eq("lin_left", exp_q.size(), 0);
        check_eq("lin_count", hs_cyc.size(), 2);
        if (hs_cyc.size() == 2) begin
            check_eq("lin_latency", hs_cyc[0] - s, 2);
            check_eq("lin_spacing", hs_cyc[1] - hs_cyc[0], 3);
        end

        // backpressure, plus start ignored while issuing
        clear_mem();
        mem[0] = 16'h0005;
        exp_q.push_back({16'h0005, 10'd0});
        issue_ready = 1'b0;
        pulse_start(s);
        n = 0;
        while (!issue_valid && n < 10) begin
            @(posedge clk); #1; n++;
        end
        check_eq("bp_valid_up", issue_valid, 1);
        h0 = hs_count;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1 start = (k == 1);
            @(negedge clk);
            check_eq("bp_hold_valid", issue_valid, 1);
            check_eq("bp_hold_instr", issue_instr, 16'h0005);
            check_eq("bp_hold_pc", issue_pc, 0);
        end
        @(posedge clk); #1 start = 1'b0; issue_ready = 1'b1;
        wait_done(40);
        check_eq("bp_one_hs", hs_count - h0, 1);
        check_eq("bp_halted", halted, 1);
        check_eq("bp_pc_adv", imem_addr, 1);
        check_eq("bp_left", exp_q.size(), 0);

        // call / return
        clear_mem();
        mem[0] = 16'hC00A; mem[10] = 16'h0003; mem[11] = 16'hE000; mem[1] = 16'hFFFF;
        exp_q.push_back({16'h0003, 10'd10});
        h0 = hs_count;
        pulse_start(s);
        wait_done(60);
        check_eq("cr_halted", halted, 1);
        check_eq("cr_err", ras_err, 0);
        check_eq("cr_halt_pc", imem_addr, 1);
        check_eq("cr_issues", hs_count - h0, 1);
        check_eq("cr_left", exp_q.size(), 0);

        // return with empty stack
        clear_mem();
        mem[0] = 16'hE000;
        h0 = hs_count;
        pulse_start(s);
        wait_done(20);
        @(negedge clk);
        check_eq("und_err", ras_err, 1);
        check_eq("und_halted", halted, 0);
        check_eq("und_issues", hs_count - h0, 0);

        // nine nested calls overflow an 8-entry stack
        clear_mem();
        for (int i = 0; i < 9; i++) mem[i] = 16'hC000 | 16'(i + 1);
        pulse_start(s);
        wait_done(80);
        @(negedge clk);
        check_eq("ovf_err", ras_err, 1);
        check_eq("ovf_at_pc", imem_addr, 8);
        check_eq("ovf_en", imem_en, 0);

        // restart from ERR
        clear_mem();
        mem[0] = 16'h0007;
        exp_q.push_back({16'h0007, 10'd0});
        pulse_start(s);
        @(negedge clk);
        check_eq("rs_err_clr", ras_err, 0);
        wait_done(40);
        check_eq("rs_halted", halted, 1);
        check_eq("rs_left", exp_q.size(), 0);

        // pc wrap: call 1023, issue there, next fetch at 0
        clear_mem();
        mem[0] = 16'hC3FF; mem[1023] = 16'h0001;
        exp_q.push_back({16'h0001, 10'd1023});
        h0 = hs_count;
        pulse_start(s);
        n = 0;
        while (hs_count == h0 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        issue_ready = 1'b0;
        check_eq("wrap_hs", hs_count - h0, 1);
        check_eq("wrap_fetch_en", imem_en, 1);
        check_eq("wrap_fetch_addr", imem_addr, 0);
        check_eq("wrap_left", exp_q.size(), 0);

        // reset while holding an issue
        n = 0;
        while (!issue_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check_eq("rst_mid_valid_pre", issue_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_mid_valid", issue_valid, 0);
        check_eq("rst_mid_en", imem_en, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        issue_ready = 1'b1;
        h0 = hs_count;
        repeat (5) begin
            @(negedge clk);
            check_eq("idle_valid", issue_valid, 0);
            check_eq("idle_en", imem_en, 0);
        end
        check_eq("idle_no_hs", hs_count - h0, 0);
        clear_mem();
        mem[0] = 16'h0009;
        exp_q.push_back({16'h0009, 10'd0});
        pulse_start(s);
        wait_done(40);
        check_eq("post_rst_left", exp_q.size(), 0);
        check_eq("post_rst_halted", halted, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
